// File: rtl/apple_line_fetcher.sv
// Apple II scanline fetcher: computes the text/lores/hires base address for a line,
// fetches the interleaved words over the shadow video port and double-buffers them for the renderer.
module apple_line_fetcher #(
    parameter int WORDS_PER_LINE = 20
) (
    input  logic        clk_logic,
    input  logic        reset,
    input  logic        line_start_i,
    input  logic [7:0]  line_i,
    input  logic        text_mode_i,
    input  logic        mixed_mode_i,
    input  logic        page2_i,
    input  logic        hires_mode_i,
    input  logic        store80_i,
    input  logic        bank_i,
    output logic        video_rd_o,
    output logic [15:0] video_address_o,
    output logic        video_bank_o,
    input  logic [31:0] video_data_i,
    input  logic        video_valid_i,
    input  logic [4:0]  buf_index_i,
    output logic [31:0] buf_data_o,
    output logic        line_ready_o,
    output logic        busy_o,
    output logic        overrun_o
);
    localparam logic [4:0] LAST_WORD = 5'(WORDS_PER_LINE - 1);
    localparam logic [5:0] HALF_SIZE = 6'(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [4:0]  k_r, k_s;
    logic [15:0] base_r, base_s;
    logic [15:0] line_base_s, page_base_s, row_off_s, group_off_s;
    logic        bank_r, bank_s, drop_r, drop_s, overrun_s, disp_r;
    logic        swap_s, wr_en_s, page2_eff_s, hires_sel_s, start_ok_s;
    logic [5:0]  wr_addr_s, rd_addr_s;
    logic [31:0] line_mem [0:2*WORDS_PER_LINE-1];

    // Line base address from the soft switches; STORE80 turns PAGE2 into an aux select
    always_comb begin
        page2_eff_s = page2_i & ~store80_i;
        hires_sel_s = hires_mode_i & ~text_mode_i & ~(mixed_mode_i & (line_i >= 8'd160));
        start_ok_s  = line_start_i & (line_i <= 8'd191);
        group_off_s = {9'd0, line_i[7:6], 5'd0} + {11'd0, line_i[7:6], 3'd0};
        if (hires_sel_s) begin
            page_base_s = page2_eff_s ? 16'h4000 : 16'h2000;
            row_off_s   = {3'd0, line_i[2:0], 10'd0} + {6'd0, line_i[5:3], 7'd0};
        end else begin
            page_base_s = page2_eff_s ? 16'h0800 : 16'h0400;
            row_off_s   = {6'd0, line_i[5:3], 7'd0};
        end
        line_base_s = page_base_s + row_off_s + group_off_s;
    end

    // Fetch sequencing, abort handling and stale-response drop
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        base_s    = base_r;
        bank_s    = bank_r;
        overrun_s = overrun_o;
        swap_s    = 1'b0;
        wr_en_s   = 1'b0;
        if (drop_r && video_valid_i) begin
            drop_s = 1'b0;
        end else begin
            drop_s = drop_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    base_s  = line_base_s;
                    bank_s  = bank_i;
                    k_s     = 5'd0;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (video_valid_i && !drop_r) begin
                    wr_en_s = 1'b1;
                    if (k_r == LAST_WORD) begin
                        state_s = ST_DONE;
                    end else begin
                        k_s     = k_r + 5'd1;
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                swap_s = 1'b1;
                if (start_ok_s) begin
                    base_s  = line_base_s;
                    bank_s  = bank_i;
                    k_s     = 5'd0;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A request issued in REQ, or still owed in WAIT, must have its response discarded
        if (line_start_i && (state_r == ST_REQ || state_r == ST_WAIT)) begin
            overrun_s = 1'b1;
            drop_s    = !(state_r == ST_WAIT && video_valid_i && !drop_r);
            wr_en_s   = 1'b0;
            if (start_ok_s) begin
                base_s  = line_base_s;
                bank_s  = bank_i;
                k_s     = 5'd0;
                state_s = ST_REQ;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            overrun_s = overrun_s;
        end
    end

    // State and registered port outputs
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            k_r             <= 5'd0;
            base_r          <= 16'd0;
            bank_r          <= 1'b0;
            drop_r          <= 1'b0;
            disp_r          <= 1'b0;
            overrun_o       <= 1'b0;
            video_rd_o      <= 1'b0;
            video_address_o <= 16'd0;
            video_bank_o    <= 1'b0;
            line_ready_o    <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            state_r         <= state_s;
            k_r             <= k_s;
            base_r          <= base_s;
            bank_r          <= bank_s;
            drop_r          <= drop_s;
            disp_r          <= disp_r ^ swap_s;
            overrun_o       <= overrun_s;
            video_rd_o      <= (state_s == ST_REQ);
            video_address_o <= base_s + {10'd0, k_s, 1'b0};
            video_bank_o    <= bank_s;
            line_ready_o    <= (state_s == ST_DONE);
            busy_o          <= (state_s == ST_REQ) || (state_s == ST_WAIT);
        end
    end

    // Fill half is the one not on display
    always_comb begin
        wr_addr_s = {1'b0, k_r} + (disp_r ? 6'd0 : HALF_SIZE);
        rd_addr_s = {1'b0, buf_index_i} + (disp_r ? HALF_SIZE : 6'd0);
    end

    // Line buffer RAM, deliberately not cleared by reset
    always_ff @(posedge clk_logic) begin
        if (wr_en_s) begin
            line_mem[wr_addr_s] <= video_data_i;
        end
    end

    // Renderer read port
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            buf_data_o <= 32'd0;
        end else if (buf_index_i <= LAST_WORD) begin
            buf_data_o <= line_mem[rd_addr_s];
        end else begin
            buf_data_o <= 32'd0;
        end
    end
endmodule

// File: tb/tb_apple_line_fetcher.sv
// Scoreboard bench for apple_line_fetcher: a randomized-latency video memory responder,
// a request/line/buffer monitor and an address reference model.
module tb_apple_line_fetcher;
    logic        clk_logic = 1'b0;
    logic        reset = 1'b1;
    logic        line_start_i = 1'b0;
    logic [7:0]  line_i = 8'd0;
    logic        text_mode_i = 1'b0, mixed_mode_i = 1'b0, page2_i = 1'b0;
    logic        hires_mode_i = 1'b0, store80_i = 1'b0, bank_i = 1'b0;
    logic        video_rd_o, video_bank_o, line_ready_o, busy_o, overrun_o;
    logic [15:0] video_address_o;
    logic [31:0] video_data_i = 32'd0;
    logic        video_valid_i = 1'b0;
    logic [4:0]  buf_index_i = 5'd0;
    logic [31:0] buf_data_o;

    apple_line_fetcher dut (
        .clk_logic(clk_logic), .reset(reset), .line_start_i(line_start_i), .line_i(line_i),
        .text_mode_i(text_mode_i), .mixed_mode_i(mixed_mode_i), .page2_i(page2_i),
        .hires_mode_i(hires_mode_i), .store80_i(store80_i), .bank_i(bank_i),
        .video_rd_o(video_rd_o), .video_address_o(video_address_o), .video_bank_o(video_bank_o),
        .video_data_i(video_data_i), .video_valid_i(video_valid_i), .buf_index_i(buf_index_i),
        .buf_data_o(buf_data_o), .line_ready_o(line_ready_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk_logic = ~clk_logic;

    typedef struct { logic [15:0] addr; logic bank; logic [15:0] tag; } req_t;
    typedef struct { logic [15:0] base; logic [15:0] tag; } line_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    req_t  exp_req_q[$];
    line_t exp_line_q[$];
    rsp_t  rsp_q[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, req_seen = 0, rsp_sent = 0, min_lat = 0;
    bit allow_multi = 1'b0;
    logic [31:0] half_m [2][20];
    bit          known_m [2][20];
    int          disp_m = 0;
    logic [31:0] exp_buf = 32'd0;
    bit          exp_buf_known = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input int act, input int req);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Reference: Apple II video address rules at line granularity
    function automatic logic [15:0] ref_base(input int line, input bit text, input bit mixed,
                                             input bit page2, input bit hires, input bit store80);
        bit p2 = page2 && !store80;
        bit hr = hires && !text && !(mixed && line >= 160);
        int b;
        if (hr) b = (p2 ? 16384 : 8192) + (line % 8) * 1024 + ((line / 8) % 8) * 128 + (line / 64) * 40;
        else    b = (p2 ? 2048 : 1024) + ((line / 8) % 8) * 128 + (line / 64) * 40;
        return b[15:0];
    endfunction

    always @(posedge clk_logic) cyc++;

    // Video memory responder: in-order responses after a random latency
    initial begin
        forever begin
            @(posedge clk_logic);
            #1;
            video_valid_i = 1'b0;
            if (reset) begin
                rsp_q.delete();
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                video_data_i  = rsp_q[0].data;
                video_valid_i = 1'b1;
                void'(rsp_q.pop_front());
                rsp_sent++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_logic);
            #1;
            buf_index_i = 5'($urandom_range(0, 23));
        end
    end

    // Monitor: requests, line completion and buffer reads against the scoreboard
    always @(negedge clk_logic) begin : mon
        req_t  e;
        line_t l;
        int    idx;
        if (!reset && video_rd_o === 1'b1) begin
            req_seen++;
            check("busy_during_req", {31'd0, busy_o}, 32'd1);
            if (!allow_multi) check("outstanding", rsp_q.size(), 32'd0);
            if (exp_req_q.size() == 0) begin
                fail("unexpected_req", int'(video_address_o), -1);
                rsp_q.push_back('{due: cyc + 1, data: 32'd0});
            end else begin
                e = exp_req_q.pop_front();
                check("req_addr", {16'd0, video_address_o}, {16'd0, e.addr});
                check("req_bank", {31'd0, video_bank_o}, {31'd0, e.bank});
                rsp_q.push_back('{due: cyc + 1 + min_lat + int'($urandom_range(0, 5 - min_lat)),
                                  data: {e.tag, e.addr}});
            end
        end
        if (exp_buf_known) check("buf_data", buf_data_o, exp_buf);
        idx = int'(buf_index_i);
        if (reset) begin
            exp_buf = 32'd0;
            exp_buf_known = 1'b1;
            disp_m = 0;
            for (int k = 0; k < 20; k++) known_m[0][k] = 1'b0;
        end else if (idx > 19) begin
            exp_buf = 32'd0;
            exp_buf_known = 1'b1;
        end else begin
            exp_buf = half_m[disp_m][idx];
            exp_buf_known = known_m[disp_m][idx];
        end
        if (!reset && line_ready_o === 1'b1) begin
            if (exp_line_q.size() == 0) begin
                fail("unexpected_line_ready", 1, 0);
            end else begin
                l = exp_line_q.pop_front();
                for (int k = 0; k < 20; k++) begin
                    half_m[1 - disp_m][k]  = {l.tag, l.base + 16'(2 * k)};
                    known_m[1 - disp_m][k] = 1'b1;
                end
                disp_m = 1 - disp_m;
            end
        end
    end

    task automatic tick();
        @(posedge clk_logic);
        #1;
    endtask

    task automatic issue(input int line, input bit text, input bit mixed, input bit page2,
                         input bit hires, input bit store80, input bit bank,
                         input int first_addr, input bit completes);
        logic [15:0] b;
        logic [15:0] tag;
        tag = 16'($urandom);
        b = (first_addr >= 0) ? 16'(first_addr) : ref_base(line, text, mixed, page2, hires, store80);
        line_i = 8'(line);
        text_mode_i = text; mixed_mode_i = mixed; page2_i = page2;
        hires_mode_i = hires; store80_i = store80; bank_i = bank;
        line_start_i = 1'b1;
        if (line <= 191) begin
            exp_req_q.delete();
            for (int k = 0; k < 20; k++) exp_req_q.push_back('{addr: b + 16'(2 * k), bank: bank, tag: tag});
            if (completes) exp_line_q.push_back('{base: b, tag: tag});
        end
        tick();
        line_start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_line_q.size() != 0 || busy_o) && n < 3000) begin
            tick();
            n++;
        end
        check("lines_pending", exp_line_q.size(), 32'd0);
        check("reqs_pending", exp_req_q.size(), 32'd0);
        repeat (8) tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_rd", {31'd0, video_rd_o}, 32'd0);
        check("rst_addr", {16'd0, video_address_o}, 32'd0);
        check("rst_bank", {31'd0, video_bank_o}, 32'd0);
        check("rst_buf", buf_data_o, 32'd0);
        check("rst_ready", {31'd0, line_ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_overrun", {31'd0, overrun_o}, 32'd0);
    endtask

    initial begin : stim
        int r0, n;
        repeat (3) tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        issue(0,   1, 0, 0, 0, 0, 0, 16'h0400, 1); wait_idle();
        issue(8,   1, 0, 0, 0, 0, 1, 16'h0480, 1); wait_idle();
        issue(64,  1, 0, 0, 0, 0, 0, 16'h0428, 1); wait_idle();
        issue(0,   1, 0, 1, 0, 0, 0, 16'h0800, 1); wait_idle();
        issue(0,   1, 0, 1, 0, 1, 1, 16'h0400, 1); wait_idle();
        issue(1,   0, 0, 0, 1, 0, 0, 16'h2400, 1); wait_idle();
        issue(191, 0, 0, 0, 1, 0, 0, 16'h3FD0, 1); wait_idle();
        issue(160, 0, 1, 0, 1, 0, 0, 16'h0650, 1); wait_idle();

        repeat (16) begin
            issue($urandom_range(0, 191), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), -1, 1);
            wait_idle();
        end

        // Next line requested in the DONE cycle of the previous one
        r0 = rsp_sent;
        issue($urandom_range(0, 191), 0, 0, 0, 1, 0, 0, -1, 1);
        n = 0;
        while (rsp_sent != r0 + 20 && n < 500) begin
            @(posedge clk_logic);
            #2;
            n++;
        end
        @(posedge clk_logic);
        #1;
        issue($urandom_range(0, 191), 1, 0, 0, 0, 0, 1, -1, 1);
        wait_idle();
        check("no_overrun_at_done", {31'd0, overrun_o}, 32'd0);

        issue(200, 1, 0, 0, 0, 0, 0, -1, 0);
        repeat (10) begin
            check("busy_line200", {31'd0, busy_o}, 32'd0);
            tick();
        end

        // Abort at word 7 with a guaranteed-stale response in flight
        allow_multi = 1'b1;
        min_lat = 2;
        r0 = req_seen;
        issue($urandom_range(0, 191), 0, 0, 1, 1, 0, 0, -1, 0);
        n = 0;
        while (req_seen < r0 + 8 && n < 500) begin
            tick();
            n++;
        end
        issue($urandom_range(0, 191), 1, 0, 0, 0, 0, 1, -1, 1);
        wait_idle();
        check("overrun_sticky", {31'd0, overrun_o}, 32'd1);
        allow_multi = 1'b0;
        min_lat = 0;
        repeat (100) tick();

        r0 = req_seen;
        issue($urandom_range(0, 191), 1, 0, 0, 0, 0, 1, -1, 0);
        n = 0;
        while (req_seen < r0 + 5 && n < 500) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        check_reset_outputs();
        tick();
        reset = 1'b0;
        exp_req_q.delete();
        exp_line_q.delete();
        tick();

        issue($urandom_range(0, 191), 0, 1, 0, 1, 0, 0, -1, 1);
        wait_idle();
        issue($urandom_range(0, 191), 1, 0, 0, 0, 0, 1, -1, 1);
        wait_idle();
        repeat (100) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
